load_store_unit: RTL and testbench

Upstream client of the MMU: accepts byte/halfword/word load and store requests from the core over a valid/ready handshake and turns each one into MMU read/write cycles. Sub-word stores become read-modify-write sequences. Loads are lane-extracted and optionally sign-extended. Responses return over a held valid/ready channel.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its lane aligner.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WRITE,
        RESP
    } state_t;

    localparam logic MMU_READ  = 1'b0;
    localparam logic MMU_WRITE = 1'b1;

    // Size code 3 has no enum member and is always illegal.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
        return (size == 2'd3)
            || ((size == SIZE_HALF) && lane[0])
            || ((size == SIZE_WORD) && (lane != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts a loaded sub-word and merges store data
// into a word read back for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] load_result,
    output logic [31:0] merged_word
);

    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    assign shift   = {lane, 3'b000};
    assign shifted = word >> shift;

    always_comb begin
        load_result = shifted;
        lane_mask   = 32'hFFFF_FFFF;
        case (size)
            SIZE_BYTE: begin
                load_result = {{24{is_signed & shifted[7]}}, shifted[7:0]};
                lane_mask   = 32'h0000_00FF << shift;
            end
            SIZE_HALF: begin
                load_result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
                lane_mask   = 32'h0000_FFFF << shift;
            end
            default: ;
        endcase
        merged_word = (word & ~lane_mask) | ((wdata << shift) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word requests into MMU read/write
// cycles, with read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mmu_address,
    output logic        mmu_mode,
    output logic [31:0] mmu_data_in,
    input  logic [31:0] mmu_data_out
);

    state_t      state;
    logic        lat_write;
    logic        lat_signed;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lane;
    logic [31:0] lat_wdata;
    logic [31:0] load_result;
    logic [31:0] merged_word;
    logic        word_store;

    assign word_store = lat_write && (lat_size == SIZE_WORD);
    assign req_ready  = (state == IDLE);

    // Decoded from the state register so an async reset drops a pending write
    // before the edge that would commit it.
    assign mmu_mode = (((state == ISSUE) && word_store) || (state == WRITE))
                      ? MMU_WRITE : MMU_READ;

    lsu_lane_align u_lane_align (
        .word        (mmu_data_out),
        .wdata       (lat_wdata),
        .lane        (lat_lane),
        .size        (lat_size),
        .is_signed   (lat_signed),
        .load_result (load_result),
        .merged_word (merged_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lat_write   <= 1'b0;
            lat_signed  <= 1'b0;
            lat_size    <= 2'd0;
            lat_lane    <= 2'd0;
            lat_wdata   <= 32'd0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'd0;
            resp_error  <= 1'b0;
            mmu_address <= 32'd0;
            mmu_data_in <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_signed <= req_signed;
                        lat_size   <= req_size;
                        lat_lane   <= req_addr[1:0];
                        lat_wdata  <= req_wdata;
                        resp_rdata <= 32'd0;
                        if (is_illegal(req_size, req_addr[1:0])) begin
                            resp_error <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            resp_error  <= 1'b0;
                            mmu_address <= {2'b00, req_addr[31:2]};
                            if (req_write && (req_size == SIZE_WORD)) begin
                                mmu_data_in <= req_wdata;
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (word_store) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (lat_write) begin
                        mmu_data_in <= merged_word;
                        state       <= WRITE;
                    end else begin
                        resp_rdata <= load_result;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small behavioural MMU model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mmu_address;
    logic        mmu_mode;
    logic [31:0] mmu_data_in;
    logic [31:0] mmu_data_out;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          offset;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          failures = 0;
    int          cycle = 0;
    int          write_count = 0;
    int          first_seen = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] mem [0:255];

    load_store_unit dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mmu_address  (mmu_address),
        .mmu_mode     (mmu_mode),
        .mmu_data_in  (mmu_data_in),
        .mmu_data_out (mmu_data_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // MMU model: 256 mapped words, registered read, anything above reads 0.
    always @(posedge clock) begin
        if (mmu_mode) begin
            write_count <= write_count + 1;
            if (mmu_address < 32'd256) mem[mmu_address[7:0]] <= mmu_data_in;
        end
        mmu_data_out <= (mmu_address < 32'd256) ? mem[mmu_address[7:0]] : 32'd0;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on each response handshake.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) first_seen = cycle;
            prev_valid = resp_valid;
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected response", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput({e.name, " rdata"}, resp_rdata, e.rdata);
                    checkOutput({e.name, " error"}, {31'd0, resp_error}, {31'd0, e.err});
                    checkOutput({e.name, " latency"}, first_seen - e.acc + 1, e.offset);
                end
            end
        end
    end

    task automatic applyStimulus(input string name, input logic wr, input logic [1:0] sz,
                                 input logic sgn, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err, input int exp_off, input bit push);
        int g = 0;
        exp_t e;
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        while (!req_ready && g < 50) begin
            @(negedge clock);
            g++;
        end
        if (!req_ready) begin
            checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        if (push) begin
            e.name   = name;
            e.rdata  = exp_rdata;
            e.err    = exp_err;
            e.acc    = cycle;
            e.offset = exp_off;
            sb.push_back(e);
        end
    endtask

    task automatic waitDone(input string name);
        int g = 0;
        while (sb.size() != 0 && g < 40) begin
            @(negedge clock);
            g++;
        end
        if (sb.size() != 0) begin
            checkOutput({name, " response timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic doTxn(input string name, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_off);
        applyStimulus(name, wr, sz, sgn, addr, wdata, exp_rdata, exp_err, exp_off, 1'b1);
        waitDone(name);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wc0;
        int g;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset mmu_mode", {31'd0, mmu_mode}, 32'd0);
        checkOutput("reset mmu_address", mmu_address, 32'd0);
        checkOutput("reset mmu_data_in", mmu_data_in, 32'd0);
        checkOutput("reset resp_rdata", resp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        doTxn("sw 140", 1'b1, 2'd2, 1'b0, 32'h140, 32'hDEADBEEF, 32'd0, 1'b0, 2);
        checkOutput("sw 140 mem", mem[8'h50], 32'hDEADBEEF);
        checkOutput("sw 140 mmu_address", mmu_address, 32'h50);
        doTxn("lw 140", 1'b0, 2'd2, 1'b0, 32'h140, 32'd0, 32'hDEADBEEF, 1'b0, 3);

        doTxn("sw 11223344", 1'b1, 2'd2, 1'b0, 32'h140, 32'h11223344, 32'd0, 1'b0, 2);
        wc0 = write_count;
        doTxn("sb 141", 1'b1, 2'd0, 1'b0, 32'h141, 32'h000000AB, 32'd0, 1'b0, 4);
        checkOutput("sb 141 mem", mem[8'h50], 32'h1122AB44);
        checkOutput("sb 141 write count", write_count - wc0, 32'd1);
        doTxn("sh 142", 1'b1, 2'd1, 1'b0, 32'h142, 32'hFFFF5566, 32'd0, 1'b0, 4);
        checkOutput("sh 142 mem", mem[8'h50], 32'h5566AB44);

        doTxn("sw 80017fff", 1'b1, 2'd2, 1'b0, 32'h140, 32'h80017FFF, 32'd0, 1'b0, 2);
        doTxn("lh signed 142", 1'b0, 2'd1, 1'b1, 32'h142, 32'd0, 32'hFFFF8001, 1'b0, 3);
        doTxn("lhu 142", 1'b0, 2'd1, 1'b0, 32'h142, 32'd0, 32'h00008001, 1'b0, 3);
        doTxn("lb signed 140", 1'b0, 2'd0, 1'b1, 32'h140, 32'd0, 32'hFFFFFFFF, 1'b0, 3);
        doTxn("lbu 143", 1'b0, 2'd0, 1'b0, 32'h143, 32'd0, 32'h00000080, 1'b0, 3);
        doTxn("lb signed 141", 1'b0, 2'd0, 1'b1, 32'h141, 32'd0, 32'h0000007F, 1'b0, 3);
        doTxn("lh signed 140", 1'b0, 2'd1, 1'b1, 32'h140, 32'd0, 32'h00007FFF, 1'b0, 3);

        wc0 = write_count;
        doTxn("lw misaligned 141", 1'b0, 2'd2, 1'b0, 32'h141, 32'd0, 32'd0, 1'b1, 1);
        doTxn("lh misaligned 143", 1'b0, 2'd1, 1'b0, 32'h143, 32'd0, 32'd0, 1'b1, 1);
        doTxn("size 3", 1'b0, 2'd3, 1'b0, 32'h140, 32'd0, 32'd0, 1'b1, 1);
        doTxn("sw misaligned 142", 1'b1, 2'd2, 1'b0, 32'h142, 32'h12345678, 32'd0, 1'b1, 1);
        checkOutput("errors write count", write_count - wc0, 32'd0);
        checkOutput("errors mem", mem[8'h50], 32'h80017FFF);

        doTxn("sw unmapped", 1'b1, 2'd2, 1'b0, 32'h8000, 32'hCAFEF00D, 32'd0, 1'b0, 2);
        doTxn("lw unmapped", 1'b0, 2'd2, 1'b0, 32'h8000, 32'd0, 32'd0, 1'b0, 3);

        // Back-pressure: response must hold while resp_ready is low.
        resp_ready = 1'b0;
        applyStimulus("lb stall", 1'b0, 2'd0, 1'b1, 32'h143, 32'd0, 32'hFFFFFF80, 1'b0, 3, 1'b1);
        g = 0;
        while (!resp_valid && g < 20) begin
            @(negedge clock);
            g++;
        end
        checkOutput("stall resp_valid rise", {31'd0, resp_valid}, 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h140;
        req_wdata = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("stall resp_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("stall resp_rdata", resp_rdata, 32'hFFFFFF80);
            checkOutput("stall req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        checkOutput("stall req_ready after", {31'd0, req_ready}, 32'd1);
        checkOutput("stall mem untouched", mem[8'h50], 32'h80017FFF);
        waitDone("lb stall");

        // Reset in the WRITE cycle of a byte store must leave memory intact.
        doTxn("sw pre-reset", 1'b1, 2'd2, 1'b0, 32'h140, 32'h11223344, 32'd0, 1'b0, 2);
        wc0 = write_count;
        applyStimulus("sb reset", 1'b1, 2'd0, 1'b0, 32'h141, 32'h000000AB, 32'd0, 1'b0, 4, 1'b0);
        g = 0;
        while (!mmu_mode && g < 20) begin
            @(negedge clock);
            g++;
        end
        checkOutput("reset test reached WRITE", {31'd0, mmu_mode}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid reset mmu_mode", {31'd0, mmu_mode}, 32'd0);
        checkOutput("mid reset req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("mid reset resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("mid reset mmu_address", mmu_address, 32'd0);
        checkOutput("mid reset mmu_data_in", mmu_data_in, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("mid reset mem", mem[8'h50], 32'h11223344);
        checkOutput("mid reset write count", write_count - wc0, 32'd0);
        doTxn("lw after reset", 1'b0, 2'd2, 1'b0, 32'h140, 32'd0, 32'h11223344, 1'b0, 3);

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
